// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sends sync 1,0,1,0, then the payload MSB first on a registered line.
// Optional even-parity trailer bit is compiled in when SYNC_FRAME_TX_PARITY_EN is defined.
module sync_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              x,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_MAX = (DATA_W > 4) ? DATA_W : 4;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
    localparam logic [CW-1:0] SYNC_LAST = CW'(32'd3);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

`ifdef SYNC_FRAME_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2, PAR = 2'd3} state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2} state_t;
`endif

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic                x_q, x_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                accept_s;
    logic                frame_end_s;
`ifdef SYNC_FRAME_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    // Reset holds ready low even though the registered flag already points at IDLE.
    assign din_ready  = ready_q & ~rst;
    assign accept_s   = din_valid & din_ready;
    assign x          = x_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    // Next-state, next-line-bit and shift-register update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        x_d         = 1'b0;
        frame_end_s = 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    frame_end_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d = DATA;
                    cnt_d   = CNT_ZERO;
                    x_d     = sh_q[DATA_W-1];
                    sh_d    = {sh_q[DATA_W-2:0], 1'b0};
                end else begin
                    // Sync bit k is 1 for even k, so the next bit equals the current index LSB.
                    cnt_d = cnt_q + CNT_ONE;
                    x_d   = cnt_q[0];
                end
            end
            DATA: begin
                if (cnt_q == DATA_LAST) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                    state_d = PAR;
                    cnt_d   = CNT_ZERO;
                    x_d     = par_q;
`else
                    frame_end_s = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    x_d   = sh_q[DATA_W-1];
                    sh_d  = {sh_q[DATA_W-2:0], 1'b0};
                end
            end
`ifdef SYNC_FRAME_TX_PARITY_EN
            PAR: begin
                frame_end_s = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                sh_d    = {DATA_W{1'b0}};
            end
        endcase

        // Frame boundary: either load a new payload (zero-gap restart) or fall back to idle.
        if (frame_end_s) begin
            if (accept_s) begin
                state_d = SYNC;
                cnt_d   = CNT_ZERO;
                sh_d    = din;
                x_d     = 1'b1;
`ifdef SYNC_FRAME_TX_PARITY_EN
                par_d   = even_parity(din);
`endif
            end else begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                sh_d    = {DATA_W{1'b0}};
                x_d     = 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
                par_d   = 1'b0;
`endif
            end
        end else begin
            state_d = state_d;
        end
    end

    // Output flags are derived from the state the line will be in next cycle.
    always_comb begin
        busy_d = (state_d != IDLE);
`ifdef SYNC_FRAME_TX_PARITY_EN
        done_d = (state_d == PAR);
`else
        done_d = (state_d == DATA) && (cnt_d == DATA_LAST);
`endif
        ready_d = (state_d == IDLE) || done_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            sh_q    <= {DATA_W{1'b0}};
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef SYNC_FRAME_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
`ifdef SYNC_FRAME_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx; expected line bit patterns are hand-written per payload.
module tb_sync_frame_tx;

    localparam int DATA_W = 8;
`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam int NB = 13;
    localparam logic [12:0] E_A5 = 13'b1010_1010_0101_0;
    localparam logic [12:0] E_01 = 13'b1010_0000_0001_1;
    localparam logic [12:0] E_F0 = 13'b1010_1111_0000_0;
    localparam logic [12:0] E_0F = 13'b1010_0000_1111_0;
    localparam logic [12:0] E_3C = 13'b1010_0011_1100_0;
    localparam logic [12:0] E_FF = 13'b1010_1111_1111_0;
`else
    localparam int NB = 12;
    localparam logic [12:0] E_A5 = 13'b0_1010_1010_0101;
    localparam logic [12:0] E_01 = 13'b0_1010_0000_0001;
    localparam logic [12:0] E_F0 = 13'b0_1010_1111_0000;
    localparam logic [12:0] E_0F = 13'b0_1010_0000_1111;
    localparam logic [12:0] E_3C = 13'b0_1010_0011_1100;
    localparam logic [12:0] E_FF = 13'b0_1010_1111_1111;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] din = 8'h00;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic              x;
    logic              busy;
    logic              frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    sync_frame_tx #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .x          (x),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; din = 8'hA5; din_valid = 1'b1;
        tick; tick;
        n_cmp++; if (x !== 1'b0) begin n_bad++; $display("FAIL reset_x: got %b want 0", x); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
        n_cmp++; if (din_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", din_ready); end
        rst = 1'b0; din_valid = 1'b0;
        #1;
        n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", din_ready); end
        tick;
        n_cmp++; if (x !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_drop: x=%b busy=%b want 0 0", x, busy); end
    endtask

    task automatic test_frames;
        logic [7:0]  pl [2];
        logic [12:0] ev [2];
        pl[0] = 8'hA5; ev[0] = E_A5;
        pl[1] = 8'h01; ev[1] = E_01;
        for (int k = 0; k < 2; k++) begin
            din = pl[k]; din_valid = 1'b1;
            n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("FAIL frame%0d_idle_ready: got %b want 1", k, din_ready); end
            tick;
            din_valid = 1'b0; din = 8'hFF;
            for (int i = 0; i < NB; i++) begin
                n_cmp++; if (x !== ev[k][NB-1-i]) begin n_bad++; $display("FAIL frame%0d_bit%0d: x=%b want %b", k, i, x, ev[k][NB-1-i]); end
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL frame%0d_busy%0d: got %b want 1", k, i, busy); end
                n_cmp++; if (frame_done !== (i == NB-1)) begin n_bad++; $display("FAIL frame%0d_done%0d: got %b want %b", k, i, frame_done, (i == NB-1)); end
                n_cmp++; if (din_ready !== (i == NB-1)) begin n_bad++; $display("FAIL frame%0d_ready%0d: got %b want %b", k, i, din_ready, (i == NB-1)); end
                tick;
            end
            n_cmp++; if (x !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin
                n_bad++; $display("FAIL frame%0d_end: x=%b busy=%b ready=%b want 0 0 1", k, x, busy, din_ready);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic exp_b;
        din = 8'hF0; din_valid = 1'b1;
        tick;
        din = 8'h0F;
        for (int i = 0; i < 2*NB; i++) begin
            if (i == NB) din_valid = 1'b0;
            exp_b = (i < NB) ? E_F0[NB-1-i] : E_0F[2*NB-1-i];
            n_cmp++; if (x !== exp_b) begin n_bad++; $display("FAIL b2b_bit%0d: x=%b want %b", i, x, exp_b); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy%0d: got %b want 1", i, busy); end
            n_cmp++; if (frame_done !== (i == NB-1 || i == 2*NB-1)) begin
                n_bad++; $display("FAIL b2b_done%0d: got %b want %b", i, frame_done, (i == NB-1 || i == 2*NB-1));
            end
            tick;
        end
        n_cmp++; if (x !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_end: x=%b busy=%b want 0 0", x, busy); end
    endtask

    task automatic test_ignore;
        din = 8'h3C; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i == 6) begin
                din = 8'hFF; din_valid = 1'b1;
                n_cmp++; if (din_ready !== 1'b0) begin n_bad++; $display("FAIL ignore_ready: got %b want 0", din_ready); end
            end
            if (i == 7) din_valid = 1'b0;
            n_cmp++; if (x !== E_3C[NB-1-i]) begin n_bad++; $display("FAIL ignore_bit%0d: x=%b want %b", i, x, E_3C[NB-1-i]); end
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (x !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL ignore_idle%0d: x=%b busy=%b want 0 0", i, x, busy); end
            tick;
        end
    endtask

    task automatic test_reset_midframe;
        din = 8'hFF; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (x !== E_FF[NB-1-i]) begin n_bad++; $display("FAIL abort_bit%0d: x=%b want %b", i, x, E_FF[NB-1-i]); end
            if (i == 5) rst = 1'b1;
            tick;
        end
        n_cmp++; if (x !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_bad++; $display("FAIL abort_state: x=%b busy=%b done=%b want 0 0 0", x, busy, frame_done);
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", din_ready); end
        tick;
        for (int i = 0; i < NB; i++) begin
            n_cmp++; if (x !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_residual%0d: x=%b busy=%b want 0 0", i, x, busy); end
            tick;
        end
    endtask

    task automatic test_loopback;
        logic [3:0] hist;
        int det;
        hist = 4'b0000; det = 0;
        din = 8'h00; din_valid = 1'b1;
        tick;
        for (int i = 0; i < 2*NB + 4; i++) begin
            if (i == NB) din_valid = 1'b0;
            hist = {hist[2:0], x};
            if (hist == 4'b1010) det++;
            tick;
        end
        n_cmp++; if (det !== 2) begin n_bad++; $display("FAIL loopback_detects: got %0d want 2", det); end
    endtask

    initial begin
        test_reset;
        test_frames;
        test_back_to_back;
        test_ignore;
        test_reset_midframe;
        test_loopback;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
